// File: rtl/comm_pkg.sv
// Shared definitions for the CommMaster/copter link: FSM encodings and opcodes.
package comm_pkg;

    typedef enum logic [1:0] {
        RX_CMD = 2'd0,
        RX_DHI = 2'd1,
        RX_DLO = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_BUSY  = 2'd2
    } tx_state_e;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] POS_ACK   = 8'hA5;

endpackage

// File: rtl/uart_frame_wrapper_if.sv
// Byte-level UART handshakes plus the command/response side of the frame wrapper.
interface uart_frame_wrapper_if;

    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        snd_resp;
    logic [7:0]  resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        frm_err;

    // The wrapper itself
    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, snd_resp, resp, tx_done,
        output clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, resp_sent, frm_err
    );

    // UART transceiver and command processor side
    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, snd_resp, resp, tx_done,
        input  clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, resp_sent, frm_err
    );

endinterface

// File: rtl/uart_frame_wrapper_frame_timer.sv
// Inter-byte idle counter; only instantiated when FRAME_TIMEOUT_EN is defined.
module frame_timer #(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    // One spare count so the increment in the expiry cycle never wraps
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr || !run) cnt_d = '0;
        else             cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = run && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_frame_wrapper.sv
// Assembles 3-byte UART frames into cmd/data and sequences 1-byte responses.
// Optional inter-byte timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_wrapper
    import comm_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_frame_wrapper_if.slave   bus
);

    localparam logic [1:0] CMD      = RX_CMD;
    localparam logic [1:0] DHI      = RX_DHI;
    localparam logic [1:0] DLO      = RX_DLO;
    localparam logic [1:0] T_IDLE   = TX_IDLE;
    localparam logic [1:0] T_START  = TX_START;
    localparam logic [1:0] T_BUSY   = TX_BUSY;

    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 2");
    end

    logic [1:0]  rx_state_q, rx_state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        frm_err_q, frm_err_d;
    logic [1:0]  tx_state_q, tx_state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        trmt_q, trmt_d;
    logic        resp_sent_q, resp_sent_d;
    logic        frame_timeout;

`ifdef FRAME_TIMEOUT_EN
    logic timer_expired;

    frame_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_frame_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.rx_rdy),
        .run     (rx_state_q != CMD),
        .expired (timer_expired)
    );

    // A byte landing in the expiry cycle keeps the frame alive
    assign frame_timeout = timer_expired && !bus.rx_rdy;
`else
    assign frame_timeout = 1'b0;
`endif

    assign bus.clr_rx_rdy = bus.rx_rdy && !rst;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rx_state_d = rx_state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        cmd_rdy_d  = cmd_rdy_q;
        frm_err_d  = frame_timeout;

        // Clear first so a final-byte set in the same cycle overrides it
        if (bus.clr_cmd_rdy) cmd_rdy_d = 1'b0;

        if (bus.rx_rdy) begin
            case (rx_state_q)
                CMD: begin
                    cmd_d      = bus.rx_data;
                    cmd_rdy_d  = 1'b0;
                    rx_state_d = DHI;
                end
                DHI: begin
                    data_d[15:8] = bus.rx_data;
                    rx_state_d   = DLO;
                end
                DLO: begin
                    data_d[7:0] = bus.rx_data;
                    cmd_rdy_d   = 1'b1;
                    rx_state_d  = CMD;
                end
                default: rx_state_d = CMD;
            endcase
        end else if (frame_timeout) begin
            rx_state_d = CMD;
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;

        case (tx_state_q)
            T_IDLE: begin
                if (bus.snd_resp) begin
                    tx_data_d  = bus.resp;
                    trmt_d     = 1'b1;
                    tx_state_d = T_START;
                end
            end
            T_START: tx_state_d = T_BUSY;
            T_BUSY: begin
                if (bus.tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= CMD;
            cmd_q       <= '0;
            data_q      <= '0;
            cmd_rdy_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            tx_state_q  <= T_IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frm_err_q   <= frm_err_d;
            tx_state_q  <= tx_state_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.data      = data_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.frm_err   = frm_err_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.trmt      = trmt_q;
    assign bus.resp_sent = resp_sent_q;

endmodule
